// File: rtl/sram_tester_if.sv
// Request/response bus between the SRAM self-test engine and the SRAM controller.
interface sram_tester_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 21
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/sram_tester.sv
// SRAM built-in self-test: writes a pattern over an address window, reads it back,
// optionally repeats with complemented data, and reports error count and first failing address.
module sram_tester #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 21,
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 255,
  parameter int INVERT_PASS = 1,
  parameter int ERR_W       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  sram_tester_if.master     mem
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] MOD_W = ADDR_W'(DATA_W);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;
  logic [1:0]        mode_q, mode_n;
  logic [DATA_W-1:0] pattern_q, pattern_n;
  logic [ERR_W-1:0]  err_n;
  logic [ADDR_W-1:0] first_n;

  logic              busy_n, done_n, pass_n, write_n, read_n;
  logic [ADDR_W-1:0] addr_out_n;
  logic [DATA_W-1:0] wdata_n;

  logic              write_q, read_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] wdata_q;

  // Expected word for an address in a given pass; the second pass is the complement.
  function automatic logic [DATA_W-1:0] gen_word(
    input logic [ADDR_W-1:0] a,
    input logic              p,
    input logic [1:0]        m,
    input logic [DATA_W-1:0] pat
  );
    logic [DATA_W+ADDR_W-1:0] wide;
    logic [DATA_W-1:0]        base;
    wide = {{DATA_W{1'b0}}, a};
    case (m)
      2'd0:    base = pat;
      2'd1:    base = wide[DATA_W-1:0];
      2'd2:    base = DATA_W'(1) << (a % MOD_W);
      default: base = a[0] ? ~pat : pat;
    endcase
    return p ? ~base : base;
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      addr           <= '0;
      phase          <= 1'b0;
      mode_q         <= '0;
      pattern_q      <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      addr_out_q     <= '0;
      wdata_q        <= '0;
    end else begin
      state          <= state_n;
      addr           <= addr_n;
      phase          <= phase_n;
      mode_q         <= mode_n;
      pattern_q      <= pattern_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      write_q        <= write_n;
      read_q         <= read_n;
      addr_out_q     <= addr_out_n;
      wdata_q        <= wdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    phase_n   = phase;
    mode_n    = mode_q;
    pattern_n = pattern_q;
    err_n     = err_count;
    first_n   = first_err_addr;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = WR_REQ;
          addr_n    = FIRST;
          phase_n   = 1'b0;
          mode_n    = mode;
          pattern_n = pattern;
          err_n     = '0;
          first_n   = '0;
        end
      end
      WR_REQ: begin
        if (mem.mem_ready) state_n = WR_GAP;
      end
      WR_GAP: begin
        if (addr == LAST) begin
          addr_n  = FIRST;
          state_n = RD_REQ;
        end else begin
          addr_n  = addr + 1'b1;
          state_n = WR_REQ;
        end
      end
      RD_REQ: begin
        if (mem.mem_ready) begin
          state_n = RD_GAP;
          if (mem.mem_rdata != gen_word(addr, phase, mode_q, pattern_q)) begin
            if (err_count == '0) first_n = addr;
            if (err_count != '1) err_n = err_count + 1'b1;
          end
        end
      end
      RD_GAP: begin
        if (addr < LAST) begin
          addr_n  = addr + 1'b1;
          state_n = RD_REQ;
        end else if (INVERT_PASS == 1 && !phase) begin
          phase_n = 1'b1;
          addr_n  = FIRST;
          state_n = WR_REQ;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they come straight out of flops.
  always_comb begin
    busy_n     = (state_n != IDLE) && (state_n != DONE);
    done_n     = (state_n == DONE);
    pass_n     = done_n && (err_n == '0);
    write_n    = (state_n == WR_REQ);
    read_n     = (state_n == RD_REQ);
    addr_out_n = addr_n;
    wdata_n    = gen_word(addr_n, phase_n, mode_n, pattern_n);
  end

  assign mem.mem_write = write_q;
  assign mem.mem_read  = read_q;
  assign mem.mem_addr  = addr_out_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: doc/sram_tester.md
# sram_tester

Parametrised built-in self-test engine for the onboard SRAM path. It sits between the top level and the `sram` controller, and drives that controller's write/read request handshake. It sweeps a configurable address window, writing a selectable data pattern and reading it back, with an optional second pass using complemented data. It reports a saturating error count, the first failing address, and a pass/fail summary.

## Interface
Parameters:
- `DATA_W`, 16, memory word width.
- `ADDR_W`, 21, SRAM address width.
- `START_ADDR`, 0, first address tested.
- `END_ADDR`, 255, last address tested. Must be ≥ `START_ADDR`.
- `INVERT_PASS`, 1, when 1 runs a second full pass with complemented data.
- `ERR_W`, 16, error counter width.

Ports:
- `clk`, in, 1, system clock.
- `nreset`, in, 1, asynchronous active-low reset.
- `start`, in, 1, begin test. Sampled only when not busy.
- `mode`, in, 2, pattern select. Latched at start.
- `pattern`, in, `DATA_W`, base pattern. Latched at start.
- `busy`, out, 1, test in progress.
- `done`, out, 1, test finished. Held until next start or reset.
- `pass`, out, 1, `done` and zero errors.
- `err_count`, out, `ERR_W`, mismatches. Saturates at all-ones.
- `first_err_addr`, out, `ADDR_W`, address of first mismatch.
- `mem_write`, out, 1, write request to controller.
- `mem_read`, out, 1, read request to controller.
- `mem_addr`, out, `ADDR_W`, request address.
- `mem_wdata`, out, `DATA_W`, write data.
- `mem_rdata`, in, `DATA_W`, read data. Valid when `mem_ready` is high during a read.
- `mem_ready`, in, 1, controller completion strobe.

## Operation
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE or DONE, `start`=1:
  - latch `mode` and `pattern`;
  - clear `err_count`, `first_err_addr`, `done`, `pass`;
  - set addr=`START_ADDR`, phase=0;
  - go to WR_REQ.
- WR_REQ: `mem_write`=1, `mem_addr`=addr, `mem_wdata`=D(addr,phase), all held stable. On the cycle `mem_ready`=1, go to WR_GAP.
- WR_GAP: both requests low for one cycle. Then:
  - if addr=`END_ADDR`, set addr=`START_ADDR` and go to RD_REQ;
  - otherwise increment addr and go to WR_REQ.
- RD_REQ: `mem_read`=1 with `mem_addr` held. On the cycle `mem_ready`=1, compare `mem_rdata` with D(addr,phase). On mismatch:
  - increment `err_count` unless it is already all-ones;
  - capture addr into `first_err_addr` if `err_count` was 0.
  - Then go to RD_GAP.
- RD_GAP: one idle cycle. Then:
  - if addr<`END_ADDR`, increment addr and go to RD_REQ;
  - else if `INVERT_PASS`=1 and phase=0, set phase=1, addr=`START_ADDR`, and go to WR_REQ;
  - else go to DONE.
- DONE: `done`=1, `pass`=(`err_count`==0). Stays here until `start`.
- Pattern D(a,p), computed as base then XORed with all-ones if p=1:
  - mode 0: `pattern`;
  - mode 1: a zero-extended or truncated to `DATA_W`;
  - mode 2: walking one, 1 << (a mod `DATA_W`);
  - mode 3: checkerboard, `pattern` if a[0]=0, else ~`pattern`.
- `mem_write` and `mem_read` are never high together.
- `start` while busy is ignored.
- `mem_ready` outside a REQ state is ignored.

## Timing
- Reset (asynchronous, immediate) forces:
  - state IDLE;
  - `busy`, `done`, `pass`, `mem_write`, `mem_read` = 0;
  - `err_count`, `first_err_addr`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-test drops any request in flight. The test is not resumed.
- `busy` rises the cycle after `start` is sampled; `mem_write` rises in that same cycle.
- Each access is ≥2 cycles: a REQ cycle ending with `mem_ready`, then a GAP cycle.
- Controller wait cycles extend REQ indefinitely, with address and data stable throughout.
- With `mem_ready` tied high, N=`END_ADDR`-`START_ADDR`+1 and P=1+`INVERT_PASS`:
  - `busy` lasts exactly 4·N·P cycles;
  - `done` rises the cycle after the final RD_GAP.
- All outputs are registered.
- `err_count` and `first_err_addr` update on the edge that ends the `mem_ready` cycle.

## Test plan
- Ideal memory model with `mem_ready` tied high, `START_ADDR`=0, `END_ADDR`=15, mode 0, `pattern`=16'h8AF5, `INVERT_PASS`=1 → `busy` for 128 cycles; `done`=1, `pass`=1, `err_count`=0. Writes to address 3 carry 16'h8AF5 in pass 0 and 16'h750A in pass 1.
- Model with bit 3 stuck-at-0 at address 5, mode 2 → only pass 1 fails at address 5 (walking one 0x0020, complemented, has bit 3 set). Result: `err_count`=1, `first_err_addr`=5, `pass`=0.
- Random 0–5 cycle `mem_ready` delays, mode 1 → address and data stable during every REQ; no overlap of `mem_write`/`mem_read`; `pass`=1.
- `nreset` pulsed low during pass 0 read at address 7 → all outputs 0 the same cycle. A fresh `start` then completes with `pass`=1.
- `start` pulsed while busy → ignored, timing unchanged. `start` in DONE → counters cleared and test reruns.
- `ERR_W`=2 with a model failing every read over 8 addresses → `err_count` saturates at 3; `first_err_addr`=`START_ADDR`.
